// File: rtl/ddr_local_burst_seq.sv
// rtl/ddr_local_burst_seq.sv - one-burst-at-a-time sequencer onto the HPC local (Avalon-style) interface
// Write beats stream through combinationally; read returns are registered with one cycle of latency.
module ddr_local_burst_seq #(
  parameter int ADDR_W    = 23,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 64
) (
  input  logic                  local_clk_i,
  input  logic                  local_reset_n_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_W-1:0]     cmd_adr_i,
  input  logic [6:0]            cmd_size_i,
  input  logic                  wdat_valid_i,
  output logic                  wdat_ready_o,
  input  logic [DATA_W-1:0]     wdat_i,
  input  logic [DATA_W/8-1:0]   wbe_i,
  output logic                  rdat_valid_o,
  output logic [DATA_W-1:0]     rdat_o,
  output logic                  busy_o,
  output logic                  err_o,
  output logic [ADDR_W-1:0]     local_address_o,
  output logic [6:0]            local_size_o,
  output logic                  local_burstbegin_o,
  output logic                  local_write_req_o,
  output logic                  local_read_req_o,
  output logic [DATA_W-1:0]     local_wdata_o,
  output logic [DATA_W/8-1:0]   local_be_o,
  input  logic [DATA_W-1:0]     local_rdata_i,
  input  logic                  local_rdata_valid_i,
  input  logic                  local_ready_i
);

  typedef enum logic [1:0] {IDLE, WRITE, READ_REQ, READ_WAIT} state_t;

  state_t     state, state_nxt;
  logic [6:0] beat_cnt;
  logic       first_beat;
  logic [6:0] size_clamped;
  logic       cmd_fire;
  logic       wr_fire;
  logic       rd_beat;

  assign size_clamped = (cmd_size_i > 7'(MAX_BURST)) ? 7'(MAX_BURST) : cmd_size_i;
  assign cmd_fire     = cmd_valid_i & (state == IDLE);
  assign wr_fire      = (state == WRITE) & wdat_valid_i & local_ready_i;
  assign rd_beat      = (state == READ_WAIT) & local_rdata_valid_i;

  assign local_wdata_o = wdat_i;
  assign local_be_o    = wbe_i;

  always_ff @(posedge local_clk_i or negedge local_reset_n_i) begin
    if (!local_reset_n_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmd_fire && (size_clamped != 7'd0)) begin
          state_nxt = cmd_we_i ? WRITE : READ_REQ;
        end
      end
      WRITE: begin
        if (wr_fire && (beat_cnt == 7'd1)) begin
          state_nxt = IDLE;
        end
      end
      READ_REQ: begin
        if (local_ready_i) begin
          state_nxt = READ_WAIT;
        end
      end
      READ_WAIT: begin
        if (rd_beat && (beat_cnt == 7'd1)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // cmd_ready is gated by reset so every output reads 0 while reset is held.
  always_comb begin
    cmd_ready_o        = 1'b0;
    wdat_ready_o       = 1'b0;
    local_write_req_o  = 1'b0;
    local_read_req_o   = 1'b0;
    local_burstbegin_o = 1'b0;
    busy_o             = (state != IDLE);
    case (state)
      IDLE: cmd_ready_o = local_reset_n_i;
      WRITE: begin
        local_write_req_o  = wdat_valid_i;
        wdat_ready_o       = local_ready_i;
        local_burstbegin_o = wdat_valid_i & first_beat;
      end
      READ_REQ: begin
        local_read_req_o   = 1'b1;
        local_burstbegin_o = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge local_clk_i or negedge local_reset_n_i) begin
    if (!local_reset_n_i) begin
      beat_cnt        <= 7'd0;
      first_beat      <= 1'b0;
      local_address_o <= '0;
      local_size_o    <= 7'd0;
      rdat_valid_o    <= 1'b0;
      rdat_o          <= '0;
      err_o           <= 1'b0;
    end else begin
      if (cmd_fire) begin
        local_address_o <= cmd_adr_i;
        local_size_o    <= size_clamped;
        beat_cnt        <= size_clamped;
        first_beat      <= 1'b1;
      end else if ((wr_fire || rd_beat) && (beat_cnt != 7'd0)) begin
        beat_cnt   <= beat_cnt - 7'd1;
        first_beat <= 1'b0;
      end
      // Read data is forwarded regardless of state; only the error flag cares.
      rdat_valid_o <= local_rdata_valid_i;
      if (local_rdata_valid_i) begin
        rdat_o <= local_rdata_i;
        if (state != READ_WAIT) begin
          err_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ddr_local_burst_seq.sv
// tb/tb_ddr_local_burst_seq.sv - directed bench with a burst-level scoreboard for ddr_local_burst_seq
module tb_ddr_local_burst_seq;
  localparam int AW = 23;
  localparam int DW = 32;
  localparam int BW = DW/8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_we = 1'b0;
  logic [AW-1:0] cmd_adr = '0;
  logic [6:0]    cmd_size = '0;
  logic          wdat_valid = 1'b0;
  logic [DW-1:0] wdat = '0;
  logic [BW-1:0] wbe = '0;
  logic [DW-1:0] l_rdata = '0;
  logic          l_rvalid = 1'b0, l_ready = 1'b1;

  logic          cmd_ready_o, wdat_ready_o, rdat_valid_o, busy_o, err_o;
  logic [DW-1:0] rdat_o, local_wdata_o;
  logic [AW-1:0] local_address_o;
  logic [6:0]    local_size_o;
  logic          local_burstbegin_o, local_write_req_o, local_read_req_o;
  logic [BW-1:0] local_be_o;

  ddr_local_burst_seq #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(64)) dut (
    .local_clk_i(clk), .local_reset_n_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_size_i(cmd_size),
    .wdat_valid_i(wdat_valid), .wdat_ready_o(wdat_ready_o), .wdat_i(wdat), .wbe_i(wbe),
    .rdat_valid_o(rdat_valid_o), .rdat_o(rdat_o), .busy_o(busy_o), .err_o(err_o),
    .local_address_o(local_address_o), .local_size_o(local_size_o),
    .local_burstbegin_o(local_burstbegin_o), .local_write_req_o(local_write_req_o),
    .local_read_req_o(local_read_req_o), .local_wdata_o(local_wdata_o), .local_be_o(local_be_o),
    .local_rdata_i(l_rdata), .local_rdata_valid_i(l_rvalid), .local_ready_i(l_ready)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Burst-level model: the active burst, its remaining beats, expected write beats in order,
  // and the one-cycle read-return pipe.
  bit            m_act, m_we, m_started, m_req, m_err, pend_v;
  int            m_left;
  logic [AW-1:0] m_adr;
  logic [6:0]    m_size;
  logic [DW-1:0] pend_d;
  logic [DW+BW-1:0] wq[$];
  logic [DW+BW-1:0] front;
  bit            was_act, rd_ok;
  int            c_wreq, c_wacc, c_bb, c_rreq, c_rdv;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_cmd_ready", cmd_ready_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_wreq", local_write_req_o, 0);
      check("rst_rreq", local_read_req_o, 0);
      check("rst_err", err_o, 0);
      m_act = 0; m_err = 0; pend_v = 0; m_req = 0; m_started = 0;
      wq.delete();
    end else begin
      was_act = m_act;
      rd_ok   = m_act && !m_we && m_req;
      check("cmd_ready", cmd_ready_o, !m_act);
      check("busy", busy_o, m_act);
      check("err", err_o, m_err);
      check("rdat_valid", rdat_valid_o, pend_v);
      if (pend_v) check("rdat", rdat_o, pend_d);
      c_wreq += int'(local_write_req_o);
      c_wacc += int'(local_write_req_o & l_ready);
      c_bb   += int'(local_burstbegin_o);
      c_rreq += int'(local_read_req_o);
      c_rdv  += int'(rdat_valid_o);
      if (m_act) begin
        check("addr_held", local_address_o, m_adr);
        check("size_held", local_size_o, m_size);
      end
      if (m_act && m_we) begin
        check("wreq", local_write_req_o, wdat_valid);
        check("wdat_ready", wdat_ready_o, l_ready);
        check("wr_bb", local_burstbegin_o, wdat_valid & !m_started);
        check("rreq_in_wr", local_read_req_o, 0);
        if (wdat_valid && l_ready) begin
          if (wq.size() == 0) check("wq_empty", 1, 0);
          else begin
            front = wq.pop_front();
            check("wdata", local_wdata_o, front[DW+BW-1:BW]);
            check("wbe", local_be_o, front[BW-1:0]);
          end
          m_started = 1;
          m_left--;
          if (m_left == 0) m_act = 0;
        end
      end else if (m_act && !m_req) begin
        check("rreq", local_read_req_o, 1);
        check("rd_bb", local_burstbegin_o, 1);
        check("wreq_in_rd", local_write_req_o, 0);
        check("wdat_ready_rd", wdat_ready_o, 0);
        if (l_ready) m_req = 1;
      end else begin
        check("rreq_off", local_read_req_o, 0);
        check("bb_off", local_burstbegin_o, 0);
        check("wreq_off", local_write_req_o, 0);
        check("wdat_ready_off", wdat_ready_o, 0);
      end
      if (l_rvalid) begin
        if (rd_ok) begin
          m_left--;
          if (m_left == 0) m_act = 0;
        end else m_err = 1;
      end
      pend_v = l_rvalid;
      pend_d = l_rdata;
      if (!was_act && cmd_valid) begin
        m_size = (cmd_size > 7'd64) ? 7'd64 : cmd_size;
        if (m_size != 0) begin
          m_act = 1; m_we = cmd_we; m_adr = cmd_adr; m_left = int'(m_size);
          m_started = 0; m_req = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_cnt();
    c_wreq = 0; c_wacc = 0; c_bb = 0; c_rreq = 0; c_rdv = 0;
  endtask

  task automatic issue_cmd(input logic we, input logic [AW-1:0] a, input logic [6:0] sz);
    cmd_valid = 1; cmd_we = we; cmd_adr = a; cmd_size = sz;
    tick();
    cmd_valid = 0;
  endtask

  task automatic run_write(input logic [AW-1:0] a, input int n, input int stall0, input int gap_at);
    logic [DW-1:0] d[$];
    logic [BW-1:0] be[$];
    int i, guard, stall;
    bit gap_done, acc;
    for (int k = 0; k < n; k++) begin
      d.push_back($urandom);
      be.push_back(BW'($urandom_range(1, 15)));
      wq.push_back({d[k], be[k]});
    end
    issue_cmd(1'b1, a, 7'(n));
    i = 0; guard = 0; gap_done = 0; stall = stall0;
    while (i < n && guard < 200) begin
      guard++;
      if (i == gap_at && !gap_done) begin
        gap_done = 1; wdat_valid = 0; l_ready = 1;
        tick();
      end else begin
        wdat_valid = 1; wdat = d[i]; wbe = be[i];
        if (i == 0 && stall > 0) begin l_ready = 0; stall--; end
        else l_ready = 1;
        @(negedge clk);
        acc = wdat_ready_o & wdat_valid;
        tick();
        if (acc) i++;
      end
    end
    if (guard >= 200) check("write_timeout", 0, 1);
    wdat_valid = 0; l_ready = 1;
    tick();
  endtask

  task automatic read_phase(input int delay, input int beats, input int gap_at);
    int k;
    bit acc;
    k = 0; acc = 0;
    while (!acc && k < 200) begin
      l_ready = (k >= delay);
      @(negedge clk);
      acc = local_read_req_o & l_ready;
      tick();
      k++;
    end
    if (!acc) check("read_req_timeout", 0, 1);
    l_ready = 1;
    for (int b = 0; b < beats; b++) begin
      if (b == gap_at) begin l_rvalid = 0; tick(); end
      l_rvalid = 1; l_rdata = $urandom;
      tick();
    end
    l_rvalid = 0;
    tick(); tick();
  endtask

  logic [DW-1:0] rd6[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    clr_cnt();
    #3;
    check("reset_cmd_ready_lit", cmd_ready_o, 0);
    tick(); tick();
    rst_n = 1;
    #1;
    check("post_reset_cmd_ready_lit", cmd_ready_o, 1);
    check("post_reset_busy_lit", busy_o, 0);
    check("post_reset_err_lit", err_o, 0);
    tick();

    clr_cnt();
    run_write(23'h100, 4, 0, -1);
    check("t1_wreq_cycles", c_wreq, 4);
    check("t1_bb_cycles", c_bb, 1);
    check("t1_accepted", c_wacc, 4);
    check("t1_idle", busy_o, 0);

    clr_cnt();
    run_write(23'h2A0, 3, 2, 2);
    check("t2_bb_cycles", c_bb, 3);
    check("t2_accepted", c_wacc, 3);
    check("t2_wreq_cycles", c_wreq, 5);

    clr_cnt();
    issue_cmd(1'b0, 23'h7FFFFF, 7'd8);
    check("t3_addr_lit", local_address_o, 23'h7FFFFF);
    read_phase(5, 8, -1);
    check("t3_rreq_cycles", c_rreq, 6);
    check("t3_bb_cycles", c_bb, 6);
    check("t3_rdv_pulses", c_rdv, 8);
    check("t3_idle", busy_o, 0);

    clr_cnt();
    issue_cmd(1'b0, 23'h40, 7'd0);
    tick(); tick(); tick();
    check("t4_null_no_req", c_rreq + c_wreq, 0);
    check("t4_null_idle", busy_o, 0);
    clr_cnt();
    issue_cmd(1'b0, 23'h80, 7'd100);
    check("t4_clamp_lit", local_size_o, 7'd64);
    read_phase(0, 64, 10);
    check("t4_rdv_pulses", c_rdv, 64);
    check("t4_one_req", c_rreq, 1);

    check("t5_err_before", err_o, 0);
    l_rvalid = 1; l_rdata = 32'hDEADBEEF;
    tick();
    l_rvalid = 0;
    @(negedge clk);
    check("t5_err_set", err_o, 1);
    check("t5_stray_pulse", rdat_valid_o, 1);
    check("t5_stray_data", rdat_o, 32'hDEADBEEF);
    tick(); tick(); tick();
    check("t5_err_sticky", err_o, 1);

    for (int k = 0; k < 4; k++) begin
      rd6[k] = $urandom;
      wq.push_back({rd6[k], 4'hF});
    end
    issue_cmd(1'b1, 23'h300, 7'd4);
    l_ready = 1; wbe = 4'hF;
    for (int k = 0; k < 2; k++) begin
      wdat_valid = 1; wdat = rd6[k];
      tick();
    end
    wdat = rd6[2];
    #1;
    check("t6_mid_burst", busy_o, 1);
    rst_n = 0;
    #1;
    check("t6_rst_cmd_ready", cmd_ready_o, 0);
    check("t6_rst_busy", busy_o, 0);
    check("t6_rst_wreq", local_write_req_o, 0);
    check("t6_rst_bb", local_burstbegin_o, 0);
    check("t6_rst_wdat_ready", wdat_ready_o, 0);
    check("t6_rst_addr", local_address_o, 0);
    check("t6_rst_size", local_size_o, 0);
    check("t6_rst_err", err_o, 0);
    check("t6_rst_rdv", rdat_valid_o, 0);
    tick(); tick();
    rst_n = 1;
    wdat_valid = 0;
    #1;
    check("t6_release_ready", cmd_ready_o, 1);
    check("t6_release_busy", busy_o, 0);
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
